// File: rtl/tcam_update_sequencer.sv
`default_nettype none
// =====================================================================
// tcam_update_sequencer : per-fragment read/modify/write of TCAM segments
// Rev 1.0
// =====================================================================
module tcam_update_sequencer #(
  parameter  int DATA_BITS  = 10,
  parameter  int FRAGMENTS  = 5,
  parameter  int FRAG_BITS  = 3,
  parameter  int IDWID      = 2,
  parameter  int MASKWID    = 5,
  localparam int c_KWID     = DATA_BITS,
  localparam int c_PRIOWID  = IDWID,
  localparam int c_FRAG_WID = DATA_BITS / FRAGMENTS,
  localparam int c_ADDR_WID = FRAG_BITS + c_FRAG_WID,
  localparam int c_SEGWID   = 2 + IDWID + MASKWID + c_KWID + c_PRIOWID
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [c_KWID-1:0]     i_key,
  input  logic [IDWID-1:0]      i_id,
  input  logic [MASKWID-1:0]    i_maskid,
  input  logic [c_PRIOWID-1:0]  i_priority,
  output logic [c_ADDR_WID-1:0] o_sdram_addr,
  output logic                  o_sdram_read,
  output logic                  o_sdram_write,
  input  logic                  i_sdram_waitrequest,
  input  logic                  i_sdram_readdatavalid,
  input  logic [c_SEGWID-1:0]   i_sdram_readdata,
  output logic [c_SEGWID-1:0]   o_sdram_writedata,
  output logic                  o_modify,
  output logic [c_KWID-1:0]     o_setting_key,
  output logic [IDWID-1:0]      o_setting_id,
  output logic [MASKWID-1:0]    o_setting_maskid,
  output logic [c_PRIOWID-1:0]  o_setting_priority,
  output logic [c_SEGWID-1:0]   o_gen_readdata,
  input  logic                  i_modify_complete,
  input  logic [c_SEGWID-1:0]   i_gen_writedata,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_RD_REQ    = 3'd1;
  localparam logic [2:0] c_RD_WAIT   = 3'd2;
  localparam logic [2:0] c_GEN_START = 3'd3;
  localparam logic [2:0] c_GEN_WAIT  = 3'd4;
  localparam logic [2:0] c_GEN_DRAIN = 3'd5;
  localparam logic [2:0] c_WR_REQ    = 3'd6;
  localparam logic [2:0] c_DONE      = 3'd7;

  localparam logic [FRAG_BITS-1:0] c_LAST = FRAG_BITS'(FRAGMENTS - 1);

  logic [2:0]            r_state;
  logic [FRAG_BITS-1:0]  r_frag;
  logic [c_KWID-1:0]     r_key;
  logic [IDWID-1:0]      r_id;
  logic [MASKWID-1:0]    r_maskid;
  logic [c_PRIOWID-1:0]  r_prio;
  logic [c_SEGWID-1:0]   r_gen_rd;
  logic [c_SEGWID-1:0]   r_wdata;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_read;
  logic                  r_write;
  logic                  r_modify;
  logic                  r_done;

  logic [2:0]            w_next;
  logic                  w_accept;
  logic                  w_frag_last;
  logic [c_FRAG_WID-1:0] w_slice;

  assign w_accept    = (r_state == c_IDLE) && r_ready && i_valid;
  assign w_frag_last = (r_frag == c_LAST);

  always_comb begin
    w_slice = '0;
    for (int f = 0; f < FRAGMENTS; f++) begin
      if (r_frag == FRAG_BITS'(f)) w_slice = r_key[f*c_FRAG_WID +: c_FRAG_WID];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:      if (w_accept) w_next = c_RD_REQ;
      c_RD_REQ:    if (!i_sdram_waitrequest) w_next = c_RD_WAIT;
      c_RD_WAIT:   if (i_sdram_readdatavalid) w_next = c_GEN_START;
      c_GEN_START: w_next = c_GEN_WAIT;
      c_GEN_WAIT:  if (i_modify_complete) w_next = c_GEN_DRAIN;
      // Only move on once the generator has dropped complete, so it is idle for the next pulse.
      c_GEN_DRAIN: if (!i_modify_complete) w_next = c_WR_REQ;
      c_WR_REQ:    if (!i_sdram_waitrequest) w_next = w_frag_last ? c_DONE : c_RD_REQ;
      c_DONE:      w_next = c_IDLE;
      default:     w_next = c_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they are all low while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_frag   <= '0;
      r_key    <= '0;
      r_id     <= '0;
      r_maskid <= '0;
      r_prio   <= '0;
      r_gen_rd <= '0;
      r_wdata  <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_modify <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ready  <= (w_next == c_IDLE);
      r_busy   <= (w_next != c_IDLE);
      r_read   <= (w_next == c_RD_REQ);
      r_write  <= (w_next == c_WR_REQ);
      r_modify <= (w_next == c_GEN_START);
      r_done   <= (w_next == c_DONE);
      if (w_accept) begin
        r_key    <= i_key;
        r_id     <= i_id;
        r_maskid <= i_maskid;
        r_prio   <= i_priority;
        r_frag   <= '0;
      end
      if ((r_state == c_RD_WAIT) && i_sdram_readdatavalid) r_gen_rd <= i_sdram_readdata;
      if ((r_state == c_GEN_DRAIN) && !i_modify_complete) r_wdata <= i_gen_writedata;
      if ((r_state == c_WR_REQ) && !i_sdram_waitrequest && !w_frag_last) r_frag <= r_frag + 1'b1;
    end
  end

  assign o_ready            = r_ready;
  assign o_busy             = r_busy;
  assign o_sdram_read       = r_read;
  assign o_sdram_write      = r_write;
  assign o_modify           = r_modify;
  assign o_done             = r_done;
  assign o_sdram_addr       = {r_frag, w_slice};
  assign o_sdram_writedata  = r_wdata;
  assign o_gen_readdata     = r_gen_rd;
  assign o_setting_key      = r_key;
  assign o_setting_id       = r_id;
  assign o_setting_maskid   = r_maskid;
  assign o_setting_priority = r_prio;

endmodule
`default_nettype wire

// File: tb/tb_tcam_update_sequencer.sv
`default_nettype none
// Bench for tcam_update_sequencer: SDRAM and status-generator responders with a
// rule-level scoreboard of expected reads, generator inputs and writes.
module tb_tcam_update_sequencer;
  localparam int c_SEG = 21;
  localparam int c_AW  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic             o_ready;
  logic [9:0]       i_key;
  logic [1:0]       i_id;
  logic [4:0]       i_maskid;
  logic [1:0]       i_priority;
  logic [c_AW-1:0]  o_sdram_addr;
  logic             o_sdram_read;
  logic             o_sdram_write;
  logic             i_sdram_waitrequest;
  logic             i_sdram_readdatavalid;
  logic [c_SEG-1:0] i_sdram_readdata;
  logic [c_SEG-1:0] o_sdram_writedata;
  logic             o_modify;
  logic [9:0]       o_setting_key;
  logic [1:0]       o_setting_id;
  logic [4:0]       o_setting_maskid;
  logic [1:0]       o_setting_priority;
  logic [c_SEG-1:0] o_gen_readdata;
  logic             i_modify_complete;
  logic [c_SEG-1:0] i_gen_writedata;
  logic             o_busy;
  logic             o_done;

  always #5 clk = ~clk;

  tcam_update_sequencer dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_key(i_key), .i_id(i_id), .i_maskid(i_maskid), .i_priority(i_priority),
    .o_sdram_addr(o_sdram_addr), .o_sdram_read(o_sdram_read), .o_sdram_write(o_sdram_write),
    .i_sdram_waitrequest(i_sdram_waitrequest), .i_sdram_readdatavalid(i_sdram_readdatavalid),
    .i_sdram_readdata(i_sdram_readdata), .o_sdram_writedata(o_sdram_writedata),
    .o_modify(o_modify), .o_setting_key(o_setting_key), .o_setting_id(o_setting_id),
    .o_setting_maskid(o_setting_maskid), .o_setting_priority(o_setting_priority),
    .o_gen_readdata(o_gen_readdata), .i_modify_complete(i_modify_complete),
    .i_gen_writedata(i_gen_writedata), .o_busy(o_busy), .o_done(o_done)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Status generator rule: empty segment gets a fresh rule, occupied one gets status 11.
  function automatic logic [c_SEG-1:0] gen_model(input logic [c_SEG-1:0] rd, input logic [9:0] k,
                                                 input logic [1:0] id, input logic [4:0] m,
                                                 input logic [1:0] p);
    if (rd[c_SEG-2] == 1'b0) return {2'b01, id, m, k, p};
    return {2'b11, rd[c_SEG-3:0]};
  endfunction

  function automatic logic [c_AW-1:0] exp_addr(input int f, input logic [9:0] k);
    logic [9:0] s;
    s = k >> (2 * f);
    return {3'(f), s[1:0]};
  endfunction

  // Stimulus-owned configuration
  int               cfg_wait, cfg_rlat, cfg_glat, cfg_ghold, stray_cnt, fill_cnt;
  logic [c_SEG-1:0] cfg_fill;

  // SDRAM model
  logic [c_SEG-1:0] mem [32];
  initial begin
    int wcnt, rd_pend, stray_seen, fill_seen;
    logic acc, acc_wr;
    logic [c_AW-1:0] acc_addr, rd_addr;
    logic [c_SEG-1:0] acc_wd;
    wcnt = 0; rd_pend = 0; stray_seen = 0; fill_seen = 0; acc = 0; acc_wr = 0;
    acc_addr = '0; rd_addr = '0; acc_wd = '0;
    i_sdram_waitrequest = 0; i_sdram_readdatavalid = 0; i_sdram_readdata = '0;
    for (int a = 0; a < 32; a++) mem[a] = '0;
    forever begin
      @(posedge clk); #1;
      i_sdram_readdatavalid = 0;
      if (fill_seen != fill_cnt) begin
        for (int a = 0; a < 32; a++) mem[a] = cfg_fill;
        fill_seen = fill_cnt;
      end
      if (!reset) begin
        wcnt = 0; rd_pend = 0; acc = 0; i_sdram_waitrequest = 0;
        continue;
      end
      if (acc) begin
        if (acc_wr) mem[acc_addr] = acc_wd;
        else begin rd_addr = acc_addr; rd_pend = cfg_rlat; end
        wcnt = 0;
      end
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin i_sdram_readdatavalid = 1; i_sdram_readdata = mem[rd_addr]; end
      end else if (stray_seen != stray_cnt) begin
        stray_seen = stray_cnt;
        i_sdram_readdatavalid = 1;
        i_sdram_readdata = '1;
      end
      if ((o_sdram_read || o_sdram_write) && wcnt < cfg_wait) begin
        i_sdram_waitrequest = 1; wcnt++;
      end else i_sdram_waitrequest = 0;
      acc = (o_sdram_read || o_sdram_write) && !i_sdram_waitrequest;
      acc_wr = o_sdram_write; acc_addr = o_sdram_addr; acc_wd = o_sdram_writedata;
    end
  end

  // Status generator model
  initial begin
    i_modify_complete = 0; i_gen_writedata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset && o_modify) begin
        i_gen_writedata = gen_model(o_gen_readdata, o_setting_key, o_setting_id,
                                    o_setting_maskid, o_setting_priority);
        repeat (cfg_glat) begin @(posedge clk); #1; end
        i_modify_complete = 1;
        repeat (cfg_ghold) begin @(posedge clk); #1; end
        i_modify_complete = 0;
      end
    end
  end

  // Scoreboard / compare process
  int wr_count = 0, done_count = 0, mod_count = 0;
  initial begin
    logic [c_AW-1:0]  exp_ra[$], exp_wa[$];
    logic [c_SEG-1:0] exp_rd[$], exp_wd[$];
    logic [c_SEG-1:0] cur_rd;
    logic [9:0] s_key; logic [1:0] s_id, s_prio; logic [4:0] s_mask;
    logic prev_stall, prev_done, prev_mod;
    logic [1:0] prev_cmd; logic [c_AW-1:0] prev_addr; logic [c_SEG-1:0] prev_wd;
    logic [c_AW-1:0] a;
    prev_stall = 0; prev_done = 0; prev_mod = 0; cur_rd = '0;
    s_key = '0; s_id = '0; s_prio = '0; s_mask = '0;
    prev_cmd = '0; prev_addr = '0; prev_wd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_ra.delete(); exp_wa.delete(); exp_rd.delete(); exp_wd.delete();
        prev_stall = 0; prev_done = 0; prev_mod = 0;
        continue;
      end
      check("rd_wr_exclusive", o_sdram_read && o_sdram_write, 0);
      check("ready_while_busy", o_ready && o_busy, 0);
      if (prev_stall) begin
        check("cmd_hold", {o_sdram_read, o_sdram_write}, prev_cmd);
        check("addr_hold", o_sdram_addr, prev_addr);
        if (prev_cmd[0]) check("wdata_hold", o_sdram_writedata, prev_wd);
      end
      prev_stall = (o_sdram_read || o_sdram_write) && i_sdram_waitrequest;
      prev_cmd = {o_sdram_read, o_sdram_write}; prev_addr = o_sdram_addr; prev_wd = o_sdram_writedata;
      if (i_valid && o_ready) begin
        check("no_overlap", exp_wa.size() == 0, 1);
        s_key = i_key; s_id = i_id; s_mask = i_maskid; s_prio = i_priority;
        for (int f = 0; f < 5; f++) begin
          a = exp_addr(f, i_key);
          exp_ra.push_back(a); exp_rd.push_back(mem[a]);
          exp_wa.push_back(a); exp_wd.push_back(gen_model(mem[a], i_key, i_id, i_maskid, i_priority));
        end
      end
      if (o_sdram_read && !i_sdram_waitrequest) begin
        check("read_expected", exp_ra.size() > 0, 1);
        if (exp_ra.size() > 0) check("read_addr", o_sdram_addr, exp_ra.pop_front());
      end
      if (o_modify) begin
        mod_count++;
        check("modify_pulse", prev_mod, 0);
        check("modify_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) begin
          cur_rd = exp_rd.pop_front();
          check("gen_readdata", o_gen_readdata, cur_rd);
        end
        check("setting_key", o_setting_key, s_key);
        check("setting_fields", {o_setting_id, o_setting_maskid, o_setting_priority}, {s_id, s_mask, s_prio});
      end
      prev_mod = o_modify;
      if (o_sdram_write && !i_sdram_waitrequest) begin
        wr_count++;
        check("write_expected", exp_wa.size() > 0, 1);
        if (exp_wa.size() > 0) begin
          check("write_addr", o_sdram_addr, exp_wa.pop_front());
          check("write_data", o_sdram_writedata, exp_wd.pop_front());
          check("gen_readdata_kept", o_gen_readdata, cur_rd);
        end
      end
      if (o_done) begin
        done_count++;
        check("done_pulse", prev_done, 0);
        check("done_all_written", exp_wa.size(), 0);
      end
      prev_done = o_done;
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1; break; end
    end
    check("accept_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic start_req(input logic [9:0] k, input logic [1:0] id, input logic [4:0] m, input logic [1:0] p);
    i_key = k; i_id = id; i_maskid = m; i_priority = p; i_valid = 1;
    wait_accept();
    i_valid = 0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (done_count >= target) begin ok = 1; break; end
    end
    check("done_timeout", ok, 1);
  endtask

  task automatic fill(input logic [c_SEG-1:0] v);
    cfg_fill = v; fill_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] c_KA = 10'b1110010011;
  localparam logic [9:0] c_KB = 10'h2C6;

  initial begin
    logic [c_SEG-1:0] image1 [32];
    int wb, db, mb, nm;
    reset = 0; i_valid = 0; i_key = '0; i_id = '0; i_maskid = '0; i_priority = '0;
    cfg_wait = 0; cfg_rlat = 1; cfg_glat = 1; cfg_ghold = 1; stray_cnt = 0; fill_cnt = 0; cfg_fill = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", o_ready, 0);
    check("rst_ctrl", {o_busy, o_sdram_read, o_sdram_write, o_modify, o_done}, 0);
    check("rst_addr", o_sdram_addr, 0);
    check("rst_data", {o_sdram_writedata, o_gen_readdata}, 0);
    @(posedge clk); #2; reset = 1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {o_ready, o_busy}, 2'b10);

    // 1: empty memory
    fill('0); wb = wr_count; db = done_count;
    start_req(c_KA, 2'd2, 5'd5, 2'd1);
    wait_done(db + 1);
    check("t1_writes", wr_count - wb, 5);
    check("t1_done", done_count - db, 1);
    check("t1_m03", mem[5'h03], 21'h0C5E4D);
    check("t1_m04", mem[5'h04], 21'h0C5E4D);
    check("t1_m09", mem[5'h09], 21'h0C5E4D);
    check("t1_m0E", mem[5'h0E], 21'h0C5E4D);
    check("t1_m13", mem[5'h13], 21'h0C5E4D);
    check("t1_m00", mem[5'h00], 21'h0);
    for (int a = 0; a < 32; a++) image1[a] = mem[a];

    // 2: fully occupied memory
    fill(21'h092345); wb = wr_count;
    start_req(c_KB, 2'd1, 5'h1A, 2'd2);
    wait_done(done_count + 1);
    check("t2_writes", wr_count - wb, 5);
    check("t2_m02", mem[5'h02], 21'h192345);
    check("t2_m05", mem[5'h05], 21'h192345);
    check("t2_m08", mem[5'h08], 21'h192345);
    check("t2_m0F", mem[5'h0F], 21'h192345);
    check("t2_m12", mem[5'h12], 21'h192345);
    check("t2_m03", mem[5'h03], 21'h092345);

    // 3: three wait states on every command, slower generator
    cfg_wait = 3; cfg_glat = 3; cfg_ghold = 2;
    fill('0);
    start_req(c_KA, 2'd2, 5'd5, 2'd1);
    wait_done(done_count + 1);
    for (int a = 0; a < 32; a++) check("t3_image", mem[a], image1[a]);
    cfg_wait = 0; cfg_glat = 1; cfg_ghold = 1;

    // 4: slow read data, stray strobes in IDLE and GEN_WAIT
    cfg_rlat = 5;
    fill('0);
    stray_cnt++;
    repeat (3) @(posedge clk);
    #1;
    i_key = c_KA; i_id = 2'd2; i_maskid = 5'd5; i_priority = 2'd1; i_valid = 1;
    wait_accept();
    i_valid = 0;
    nm = 0;
    for (int c = 0; c < 500 && nm == 0; c++) begin @(negedge clk); if (o_modify) nm++; end
    check("t4_mod_timeout", nm, 1);
    stray_cnt++;
    wait_done(done_count + 1);
    for (int a = 0; a < 32; a++) check("t4_image", mem[a], image1[a]);
    cfg_rlat = 1;

    // 5: back-to-back requests
    fill('0); wb = wr_count; db = done_count; mb = mod_count;
    i_key = c_KA; i_id = 2'd2; i_maskid = 5'd5; i_priority = 2'd1; i_valid = 1;
    wait_accept();
    i_key = c_KB; i_id = 2'd1; i_maskid = 5'h1A; i_priority = 2'd2;
    wait_accept();
    i_valid = 0;
    wait_done(db + 2);
    check("t5_done", done_count - db, 2);
    check("t5_modify", mod_count - mb, 10);
    check("t5_writes", wr_count - wb, 10);

    // 6: reset in GEN_WAIT of fragment 2
    fill('0); wb = wr_count;
    i_key = c_KA; i_id = 2'd2; i_maskid = 5'd5; i_priority = 2'd1; i_valid = 1;
    wait_accept();
    i_valid = 0;
    nm = 0;
    for (int c = 0; c < 2000 && nm < 3; c++) begin @(negedge clk); if (o_modify) nm++; end
    check("t6_mod_timeout", nm, 3);
    @(posedge clk); #2; reset = 0;
    @(negedge clk);
    check("t6_rst_ctrl", {o_ready, o_busy, o_sdram_read, o_sdram_write, o_modify, o_done}, 0);
    check("t6_rst_addr", o_sdram_addr, 0);
    check("t6_rst_data", {o_sdram_writedata, o_gen_readdata}, 0);
    check("t6_rst_setting", {o_setting_key, o_setting_id, o_setting_maskid, o_setting_priority}, 0);
    check("t6_writes_before", wr_count - wb, 2);
    repeat (2) @(posedge clk);
    #2; reset = 1;
    repeat (30) @(negedge clk);
    check("t6_ready_after", {o_ready, o_busy}, 2'b10);
    check("t6_no_more_writes", wr_count - wb, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
